// File: rtl/branch_sequencer.sv
// Five-state conditional-branch sequencer: subtract, judge, compute target, complete.
// Optional BRANCH_SEQ_STATS_EN adds saturating taken/not-taken counters.
module branch_sequencer #(
    parameter int XLEN    = 16,
    parameter int PC_STEP = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    input  logic [1:0]      btype,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] offset,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic            taken,
    output logic [XLEN-1:0] pc_next,
    output logic            pc_write
`ifdef BRANCH_SEQ_STATS_EN
    ,
    input  logic            stats_clear,
    output logic [15:0]     taken_count,
    output logic [15:0]     not_taken_count
`endif
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SUB    = 3'd1,
        JUDGE  = 3'd2,
        TARGET = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t state, state_nxt;

    logic [XLEN-1:0] rs1_q, rs2_q, pc_q, off_q;
    logic [1:0]      btype_q;
    logic [XLEN:0]   diff_q;
    logic            cond_q;
    logic            cond;
    logic            accept;

    assign req_ready = (state == IDLE) && !flush && !rst;
    assign accept    = req_valid && req_ready;
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign pc_write  = done && taken;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = SUB;
            SUB:     state_nxt = flush ? IDLE : JUDGE;
            JUDGE:   state_nxt = flush ? IDLE : TARGET;
            TARGET:  state_nxt = flush ? IDLE : DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // diff is one bit wider than the operands, so its sign bit is always exact
    always_comb begin
        cond = 1'b0;
        case (btype_q)
            2'd0: cond = (diff_q == '0);
            2'd1: cond = !diff_q[XLEN];
            2'd2: cond = !diff_q[XLEN] && (diff_q != '0);
            2'd3: cond = (diff_q != '0);
            default: cond = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rs1_q   <= '0;
            rs2_q   <= '0;
            pc_q    <= '0;
            off_q   <= '0;
            btype_q <= '0;
            diff_q  <= '0;
            cond_q  <= 1'b0;
            taken   <= 1'b0;
            pc_next <= '0;
        end else begin
            if (accept) begin
                rs1_q   <= rs1_val;
                rs2_q   <= rs2_val;
                pc_q    <= pc;
                off_q   <= offset;
                btype_q <= btype;
            end
            if (state == SUB && !flush)
                diff_q <= {rs1_q[XLEN-1], rs1_q} - {rs2_q[XLEN-1], rs2_q};
            if (state == JUDGE && !flush)
                cond_q <= cond;
            // visible results only change for branches that will reach DONE
            if (state == TARGET && !flush) begin
                taken   <= cond_q;
                pc_next <= cond_q ? (pc_q + off_q) : (pc_q + XLEN'(PC_STEP));
            end
        end
    end

`ifdef BRANCH_SEQ_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            taken_count     <= '0;
            not_taken_count <= '0;
        end else if (stats_clear) begin
            taken_count     <= '0;
            not_taken_count <= '0;
        end else if (state == DONE) begin
            if (taken && taken_count != '1)
                taken_count <= taken_count + 16'd1;
            if (!taken && not_taken_count != '1)
                not_taken_count <= not_taken_count + 16'd1;
        end
    end
`endif

endmodule

// File: doc/branch_sequencer.md
# branch_sequencer

Multi-cycle branch controller for the CPU's execute stage. It accepts one conditional-branch request at a time. It registers the signed operand difference and evaluates the branch condition on it, using the same four-way condition encoding as the branching judge. It then computes the next PC and issues a one-cycle completion pulse with a PC write strobe. The main control FSM hands it branch instructions and stalls on `busy` until `done`.

## Interface
Parameters:
- `XLEN`, 16, data and address width
- `PC_STEP`, 4, fall-through increment

Ports:
- `clk`  in  1  system clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `req_valid`  in  1  branch request present
- `req_ready`  out  1  request can be accepted this cycle
- `rs1_val`  in  XLEN  signed operand 1
- `rs2_val`  in  XLEN  signed operand 2
- `btype`  in  2  condition select
- `pc`  in  XLEN  PC of the branch instruction
- `offset`  in  XLEN  signed branch offset
- `flush`  in  1  synchronous abort of the in-flight branch
- `busy`  out  1  FSM not in IDLE
- `done`  out  1  one-cycle completion pulse
- `taken`  out  1  condition result of the last completed branch
- `pc_next`  out  XLEN  next PC of the last completed branch
- `pc_write`  out  1  `done & taken`

## Operation
- FSM states:
  - IDLE: `req_ready = !flush`. An accepted request (`req_valid & req_ready`) latches all request inputs and moves to SUB.
  - SUB: registers `diff = sext(rs1) - sext(rs2)` at XLEN+1 bits, so the result never overflows. Moves to JUDGE.
  - JUDGE: registers the condition result. Moves to TARGET.
  - TARGET: registers `pc_next`. Moves to DONE.
  - DONE: asserts `done` (decoded from state) and returns to IDLE.
- Condition on `diff`, set by `btype`:
  - 0: `diff == 0` (EQ)
  - 1: `diff >= 0` (GE)
  - 2: `diff > 0` (GT)
  - 3: `diff != 0` (NE)
- `pc_next`:
  - `pc + offset` if taken, else `pc + PC_STEP`.
  - Modulo 2^XLEN; wrap-around is silent.
- `taken` and `pc_next` hold their values from DONE until the DONE of the next branch. They are not updated for flushed branches.
- `flush`:
  - In SUB, JUDGE or TARGET: the FSM returns to IDLE next cycle, with no `done` and no output update.
  - In DONE: ignored; completion proceeds.
  - In IDLE: blocks acceptance.
- Requests presented while `busy` are not accepted and must be held by the requester.

## Timing
- Acceptance in cycle T:
  - SUB at T+1, JUDGE at T+2, TARGET at T+3.
  - DONE at T+4: `done`/`pc_write` high for exactly that cycle.
  - IDLE at T+5: earliest next acceptance.
- Latency is 4 cycles from acceptance to `done`; throughput is one branch per 5 cycles.
- `taken`/`pc_next` are valid from the DONE cycle of their branch.
- Reset (asynchronous, any state including mid-branch):
  - state IDLE
  - `busy`, `done`, `taken`, `pc_write` = 0
  - `pc_next` = 0
  - internal registers = 0
  - `req_ready` = 1 once reset deasserts and `flush` is low
- The first acceptance is possible on the first clock edge after reset deasserts.

## Configuration
- `BRANCH_SEQ_STATS_EN` defined:
  - Adds `stats_clear` (in, 1), `taken_count` (out, 16) and `not_taken_count` (out, 16).
  - The matching counter increments in the DONE cycle.
  - Counters saturate at 0xFFFF.
  - `stats_clear` zeroes both synchronously and takes priority over an increment in the same cycle.
  - Reset zeroes both counters.
- Not defined: those ports and counters are absent; all other behaviour is identical.

## Test plan
- Condition sweep. Operands `rs1=5,rs2=5`, `rs1=8,rs2=5`, `rs1=-94,rs2=5`, each combined with `btype=0..3`, `pc=0x0100`, `offset=0x0020`:
  - taken patterns 1,1,0,0 / 0,1,1,1 / 0,0,0,1 respectively.
  - `pc_next` is 0x0120 when taken, 0x0104 otherwise.
- Overflow: `rs1=0x7FFF`, `rs2=0x8000`, `btype=2` -> taken=1 (17-bit diff is positive).
- Timing: accept at T -> `busy` high T+1..T+4, `done` high only at T+4, `req_ready` low T+1..T+4, new request accepted at T+5.
- Wrap: `pc=0xFFF0`, `offset=0x0020`, taken -> `pc_next=0x0010`. Not taken with `pc=0xFFFE` -> `pc_next=0x0002`.
- Flush and reset:
  - `flush` at T+2 -> no `done`, `taken`/`pc_next` keep prior values, IDLE at T+3.
  - `flush` at T+4 -> `done` still pulses.
  - `rst` pulse at T+2 -> all outputs 0 immediately.
- With `BRANCH_SEQ_STATS_EN`:
  - 3 taken + 2 not-taken branches -> counts 3/2.
  - `stats_clear` coinciding with a DONE -> both 0.
